// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - memory-side bus between the load/store unit and data memory
interface load_store_unit_if;
    logic        mem_req;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_wstrb;
    logic        mem_ack;
    logic [63:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - single-outstanding load/store unit with lane steering, alignment check and ack timeout
module load_store_unit #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                      Clk,
    input  logic                      Rst,
    input  logic                      in_valid,
    input  logic                      in_we,
    input  logic [1:0]                in_size,
    input  logic                      in_unsigned,
    input  logic [63:0]               in_addr,
    input  logic [63:0]               in_wr_data,
    output logic [63:0]               out_rd_data,
    output logic                      out_busy,
    output logic                      out_done,
    output logic                      out_misalign,
    output logic                      out_err,
    load_store_unit_if.master         mem
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE, S_FAULT} state_t;

    // Last WAIT cycle index: the counter starts at 0, so TIMEOUT cycles end at TIMEOUT-1.
    localparam logic [7:0] L_LAST = 8'(TIMEOUT - 1);

    state_t      r_state;
    state_t      w_next;
    logic [7:0]  r_cnt;
    logic        r_err;
    logic        r_we;
    logic [1:0]  r_size;
    logic        r_unsigned;
    logic [63:0] r_addr;
    logic [63:0] r_wr_data;
    logic [63:0] r_rd_data;

    logic        w_misalign;
    logic [63:0] w_shift;
    logic [63:0] w_load;
    logic [7:0]  w_strb_base;

    always_comb begin
        w_misalign = 1'b0;
        case (in_size)
            2'd1:    w_misalign = in_addr[0];
            2'd2:    w_misalign = |in_addr[1:0];
            2'd3:    w_misalign = |in_addr[2:0];
            default: w_misalign = 1'b0;
        endcase
    end

    always_comb begin
        w_shift = mem.mem_rdata >> {r_addr[2:0], 3'b000};
        w_load  = w_shift;
        case (r_size)
            2'd0:    w_load = r_unsigned ? {56'd0, w_shift[7:0]}  : {{56{w_shift[7]}},  w_shift[7:0]};
            2'd1:    w_load = r_unsigned ? {48'd0, w_shift[15:0]} : {{48{w_shift[15]}}, w_shift[15:0]};
            2'd2:    w_load = r_unsigned ? {32'd0, w_shift[31:0]} : {{32{w_shift[31]}}, w_shift[31:0]};
            default: w_load = w_shift;
        endcase
    end

    always_comb begin
        w_strb_base = 8'hFF;
        case (r_size)
            2'd0:    w_strb_base = 8'h01;
            2'd1:    w_strb_base = 8'h03;
            2'd2:    w_strb_base = 8'h0F;
            default: w_strb_base = 8'hFF;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (in_valid) w_next = w_misalign ? S_FAULT : S_WAIT;
            S_WAIT:  if (mem.mem_ack || r_cnt == L_LAST) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            S_FAULT: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        mem.mem_req  = (r_state == S_WAIT);
        mem.mem_we   = (r_state == S_WAIT) && r_we;
        mem.mem_addr = {r_addr[63:3], 3'b000};
        mem.mem_wdata = r_we ? (r_wr_data << {r_addr[2:0], 3'b000}) : 64'd0;
        mem.mem_wstrb = r_we ? (w_strb_base << r_addr[2:0]) : 8'd0;
        out_busy     = (r_state != S_IDLE);
        out_done     = (r_state == S_DONE) || (r_state == S_FAULT);
        out_misalign = (r_state == S_FAULT);
        out_err      = (r_state == S_DONE) && r_err;
        out_rd_data  = r_rd_data;
    end

    // Request capture, ack/timeout bookkeeping and the load-result register.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_cnt      <= 8'd0;
            r_err      <= 1'b0;
            r_rd_data  <= 64'd0;
            r_we       <= 1'b0;
            r_size     <= 2'd0;
            r_unsigned <= 1'b0;
            r_addr     <= 64'd0;
            r_wr_data  <= 64'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_we       <= in_we;
                        r_size     <= in_size;
                        r_unsigned <= in_unsigned;
                        r_addr     <= in_addr;
                        r_wr_data  <= in_wr_data;
                        r_cnt      <= 8'd0;
                        r_err      <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (mem.mem_ack) begin
                        if (!r_we) r_rd_data <= w_load;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                        if (r_cnt == L_LAST) r_err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed vector bench for load_store_unit
module tb_load_store_unit;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        in_valid;
    logic        in_we;
    logic [1:0]  in_size;
    logic        in_unsigned;
    logic [63:0] in_addr;
    logic [63:0] in_wr_data;
    logic [63:0] out_rd_data;
    logic        out_busy;
    logic        out_done;
    logic        out_misalign;
    logic        out_err;

    load_store_unit_if mem_bus ();

    load_store_unit #(.TIMEOUT(16)) dut (
        .Clk          (Clk),
        .Rst          (Rst),
        .in_valid     (in_valid),
        .in_we        (in_we),
        .in_size      (in_size),
        .in_unsigned  (in_unsigned),
        .in_addr      (in_addr),
        .in_wr_data   (in_wr_data),
        .out_rd_data  (out_rd_data),
        .out_busy     (out_busy),
        .out_done     (out_done),
        .out_misalign (out_misalign),
        .out_err      (out_err),
        .mem          (mem_bus.master)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] rdata;
        int          delay;
        logic        mis;
        logic [63:0] exp_wdata;
        logic [7:0]  exp_wstrb;
        logic [63:0] exp_rd;
    } vec_t;

    vec_t vecs [14];
    int   n_vec  = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
        end
    endtask

    task automatic step;
        @(posedge Clk);
        #1;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        string tag;
        tag = $sformatf("v%0d", idx);
        in_valid    = 1'b1;
        in_we       = v.we;
        in_size     = v.size;
        in_unsigned = v.uns;
        in_addr     = v.addr;
        in_wr_data  = v.wdata;
        step;
        in_valid = 1'b0;
        if (v.mis) begin
            check({tag, " fault mem_req"}, {63'd0, mem_bus.mem_req}, 64'd0);
            check({tag, " fault done"}, {63'd0, out_done}, 64'd1);
            check({tag, " fault misalign"}, {63'd0, out_misalign}, 64'd1);
            check({tag, " fault err"}, {63'd0, out_err}, 64'd0);
            check({tag, " fault rd_data"}, out_rd_data, v.exp_rd);
        end else begin
            for (int k = 1; k <= v.delay; k++) begin
                check({tag, " mem_req"}, {63'd0, mem_bus.mem_req}, 64'd1);
                check({tag, " done early"}, {63'd0, out_done}, 64'd0);
                check({tag, " mem_we"}, {63'd0, mem_bus.mem_we}, {63'd0, v.we});
                check({tag, " mem_addr"}, mem_bus.mem_addr, v.addr & ~64'h7);
                check({tag, " mem_wdata"}, mem_bus.mem_wdata, v.exp_wdata);
                check({tag, " mem_wstrb"}, {56'd0, mem_bus.mem_wstrb}, {56'd0, v.exp_wstrb});
                if (k == v.delay) begin
                    mem_bus.mem_ack   = 1'b1;
                    mem_bus.mem_rdata = v.rdata;
                end
                step;
                mem_bus.mem_ack   = 1'b0;
                mem_bus.mem_rdata = 64'hA5A5_A5A5_A5A5_A5A5;
            end
            check({tag, " done"}, {63'd0, out_done}, 64'd1);
            check({tag, " done mem_req"}, {63'd0, mem_bus.mem_req}, 64'd0);
            check({tag, " err"}, {63'd0, out_err}, 64'd0);
            check({tag, " misalign"}, {63'd0, out_misalign}, 64'd0);
            check({tag, " rd_data"}, out_rd_data, v.exp_rd);
        end
        step;
        check({tag, " done after"}, {63'd0, out_done}, 64'd0);
        check({tag, " busy after"}, {63'd0, out_busy}, 64'd0);
    endtask

    initial begin
        int req_cycles;

        //           we    sz    uns   addr          wdata                  rdata                  dly mis exp_wdata              strb   exp_rd
        vecs[0]  = '{1'b0, 2'd0, 1'b0, 64'h1003, 64'h0,                 64'h0000_0000_8000_0000, 1, 1'b0, 64'h0,                 8'h00, 64'hFFFF_FFFF_FFFF_FF80};
        vecs[1]  = '{1'b0, 2'd2, 1'b1, 64'h2004, 64'h0,                 64'hDEAD_BEEF_0000_0000, 2, 1'b0, 64'h0,                 8'h00, 64'h0000_0000_DEAD_BEEF};
        vecs[2]  = '{1'b1, 2'd1, 1'b0, 64'h3006, 64'h1234,              64'h0,                   3, 1'b0, 64'h1234_0000_0000_0000, 8'hC0, 64'h0000_0000_DEAD_BEEF};
        vecs[3]  = '{1'b0, 2'd2, 1'b0, 64'h4002, 64'h0,                 64'h0,                   1, 1'b1, 64'h0,                 8'h00, 64'h0000_0000_DEAD_BEEF};
        vecs[4]  = '{1'b0, 2'd1, 1'b0, 64'h5002, 64'h0,                 64'h0000_0000_8001_0000, 1, 1'b0, 64'h0,                 8'h00, 64'hFFFF_FFFF_FFFF_8001};
        vecs[5]  = '{1'b0, 2'd0, 1'b1, 64'h6007, 64'h0,                 64'hF100_0000_0000_0000, 1, 1'b0, 64'h0,                 8'h00, 64'h0000_0000_0000_00F1};
        vecs[6]  = '{1'b0, 2'd2, 1'b0, 64'h7000, 64'h0,                 64'h1122_3344_8899_AABB, 2, 1'b0, 64'h0,                 8'h00, 64'hFFFF_FFFF_8899_AABB};
        vecs[7]  = '{1'b0, 2'd3, 1'b0, 64'h8000, 64'h0,                 64'h0123_4567_89AB_CDEF, 4, 1'b0, 64'h0,                 8'h00, 64'h0123_4567_89AB_CDEF};
        vecs[8]  = '{1'b1, 2'd0, 1'b0, 64'h9005, 64'hA5,                64'h0,                   1, 1'b0, 64'h0000_A500_0000_0000, 8'h20, 64'h0123_4567_89AB_CDEF};
        vecs[9]  = '{1'b1, 2'd2, 1'b0, 64'hA004, 64'hCAFE_BABE,         64'h0,                   2, 1'b0, 64'hCAFE_BABE_0000_0000, 8'hF0, 64'h0123_4567_89AB_CDEF};
        vecs[10] = '{1'b1, 2'd3, 1'b0, 64'hB000, 64'h0102_0304_0506_0708, 64'h0,                 1, 1'b0, 64'h0102_0304_0506_0708, 8'hFF, 64'h0123_4567_89AB_CDEF};
        vecs[11] = '{1'b1, 2'd1, 1'b0, 64'hC001, 64'hBEEF,              64'h0,                   1, 1'b1, 64'h0,                 8'h00, 64'h0123_4567_89AB_CDEF};
        vecs[12] = '{1'b0, 2'd3, 1'b0, 64'hD004, 64'h0,                 64'h0,                   1, 1'b1, 64'h0,                 8'h00, 64'h0123_4567_89AB_CDEF};
        vecs[13] = '{1'b0, 2'd2, 1'b0, 64'hE000, 64'h0,                 64'h0000_0000_7FFF_FFFF, 1, 1'b0, 64'h0,                 8'h00, 64'h0000_0000_7FFF_FFFF};

        Rst = 1'b1;
        in_valid = 1'b0; in_we = 1'b0; in_size = 2'd0; in_unsigned = 1'b0;
        in_addr = 64'd0; in_wr_data = 64'd0;
        mem_bus.mem_ack = 1'b0;
        mem_bus.mem_rdata = 64'hA5A5_A5A5_A5A5_A5A5;
        step;
        step;
        Rst = 1'b0;
        check("reset rd_data", out_rd_data, 64'd0);
        check("reset busy", {63'd0, out_busy}, 64'd0);
        check("reset done", {63'd0, out_done}, 64'd0);
        check("reset misalign", {63'd0, out_misalign}, 64'd0);
        check("reset err", {63'd0, out_err}, 64'd0);
        check("reset mem_req", {63'd0, mem_bus.mem_req}, 64'd0);
        step;

        for (int i = 0; i < 14; i++) run_vec(i, vecs[i]);

        // Ack while idle must not disturb the load register.
        mem_bus.mem_ack = 1'b1;
        mem_bus.mem_rdata = 64'h1111_2222_3333_4444;
        step;
        mem_bus.mem_ack = 1'b0;
        check("idle ack busy", {63'd0, out_busy}, 64'd0);
        check("idle ack done", {63'd0, out_done}, 64'd0);
        check("idle ack rd_data", out_rd_data, 64'h0000_0000_7FFF_FFFF);

        // Timeout with in_valid held high during WAIT (must be ignored).
        in_valid = 1'b1; in_we = 1'b0; in_size = 2'd3; in_unsigned = 1'b0;
        in_addr = 64'hF000; in_wr_data = 64'd0;
        step;
        in_addr = 64'h1238;
        req_cycles = 0;
        for (int c = 0; c < 40 && mem_bus.mem_req; c++) begin
            req_cycles++;
            check("timeout mem_addr", mem_bus.mem_addr, 64'hF000);
            step;
        end
        in_valid = 1'b0;
        check("timeout req cycles", 64'(req_cycles), 64'd16);
        check("timeout done", {63'd0, out_done}, 64'd1);
        check("timeout err", {63'd0, out_err}, 64'd1);
        check("timeout rd_data", out_rd_data, 64'h0000_0000_7FFF_FFFF);
        step;
        check("timeout done after", {63'd0, out_done}, 64'd0);
        check("timeout busy after", {63'd0, out_busy}, 64'd0);

        // Reset during the second WAIT cycle, then a late ack.
        in_valid = 1'b1; in_we = 1'b0; in_size = 2'd0; in_unsigned = 1'b0;
        in_addr = 64'h1000;
        step;
        in_valid = 1'b0;
        check("rst1 mem_req", {63'd0, mem_bus.mem_req}, 64'd1);
        step;
        check("rst2 mem_req", {63'd0, mem_bus.mem_req}, 64'd1);
        Rst = 1'b1;
        step;
        Rst = 1'b0;
        check("rst mem_req", {63'd0, mem_bus.mem_req}, 64'd0);
        check("rst done", {63'd0, out_done}, 64'd0);
        check("rst rd_data", out_rd_data, 64'd0);
        check("rst busy", {63'd0, out_busy}, 64'd0);
        mem_bus.mem_ack = 1'b1;
        mem_bus.mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
        step;
        mem_bus.mem_ack = 1'b0;
        check("late ack done", {63'd0, out_done}, 64'd0);
        check("late ack rd_data", out_rd_data, 64'd0);
        step;
        check("late ack done2", {63'd0, out_done}, 64'd0);
        check("late ack busy", {63'd0, out_busy}, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
